// File: rtl/host_feeder.sv
// Host-side feeder for the AES core: buffers {type, data} words and replays them as atomic 4-word bursts.
// Optional per-type block counters are compiled in with `define HOST_FEEDER_STATS_EN.
module host_feeder #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [1:0]  host_type,
  input  logic [31:0] host_data,
  output logic        data_in_valid,
  output logic [1:0]  data_in_type,
  output logic [31:0] data_in,
  input  logic        crypto_ready,
  output logic        type_err
`ifdef HOST_FEEDER_STATS_EN
  ,
  output logic [15:0] key_blocks,
  output logic [15:0] data_blocks
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [1:0] TYPE_DATA = 2'b00;
  localparam logic [1:0] TYPE_KEY  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_BURST = 2'b01,
    S_GAP   = 2'b10
  } state_t;

  logic [33:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_beat;
  logic [GW-1:0] r_gap;
  logic [1:0]    r_w0_type;
  logic          r_valid;
  logic [1:0]    r_type_out;
  logic [31:0]   r_data;
  logic          r_type_err;

  logic          w_wr;
  logic          w_pop;
  logic          w_go;
  logic          w_last;
  logic          w_word_err;
  logic [1:0]    w_head_type;
  logic [31:0]   w_head_data;

  assign w_head_type = r_mem[r_rd_ptr][33:32];
  assign w_head_data = r_mem[r_rd_ptr][31:0];
  assign host_ready  = !rst && (r_count < CW'(DEPTH));
  assign w_wr        = host_valid && host_ready;
  // Reserved types are always an error; words 1..3 must also match word 0.
  assign w_word_err  = w_head_type[1] || ((r_state == S_BURST) && (w_head_type != r_w0_type));

  // Burst sequencing: a reserved head type is gated like data since it is emitted as data.
  // The IDLE decision cycle is itself the last idle cycle, so GAP holds GAP_CYCLES-1 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_pop       = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count >= CW'(4)) && ((w_head_type == TYPE_KEY) || crypto_ready)) begin
          w_go        = 1'b1;
          w_pop       = 1'b1;
          w_state_nxt = S_BURST;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BURST: begin
        if (r_beat != 3'd4) begin
          w_pop       = 1'b1;
          w_state_nxt = S_BURST;
        end else begin
          w_last      = 1'b1;
          w_state_nxt = (GAP_CYCLES > 1) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap == GW'(GAP_CYCLES - 2)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FIFO storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {host_type, host_data};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered stream-in outputs, burst/gap counters and sticky type error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_data     <= 32'd0;
      r_type_out <= TYPE_DATA;
      r_w0_type  <= TYPE_DATA;
      r_type_err <= 1'b0;
      r_beat     <= 3'd0;
      r_gap      <= '0;
    end else begin
      if (w_pop) begin
        r_valid <= 1'b1;
        r_data  <= w_head_data;
        if (w_word_err) begin
          r_type_err <= 1'b1;
        end
      end else begin
        r_valid <= 1'b0;
        r_data  <= 32'd0;
      end
      if (w_go) begin
        r_w0_type  <= w_head_type;
        r_type_out <= w_head_type[1] ? TYPE_DATA : w_head_type;
        r_beat     <= 3'd1;
      end else if (w_pop) begin
        r_beat     <= r_beat + 3'd1;
      end else begin
        r_type_out <= TYPE_DATA;
      end
      if (w_last) begin
        r_gap <= '0;
      end else if (r_state == S_GAP) begin
        r_gap <= r_gap + GW'(1);
      end
    end
  end

  assign data_in_valid = r_valid;
  assign data_in_type  = r_type_out;
  assign data_in       = r_data;
  assign type_err      = r_type_err;

`ifdef HOST_FEEDER_STATS_EN
  logic [15:0] r_key_blocks;
  logic [15:0] r_data_blocks;

  // Block counters advance on each burst's first word and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_blocks  <= 16'd0;
      r_data_blocks <= 16'd0;
    end else if (w_go) begin
      if (w_head_type == TYPE_KEY) begin
        r_key_blocks <= r_key_blocks + 16'd1;
      end else begin
        r_data_blocks <= r_data_blocks + 16'd1;
      end
    end
  end

  assign key_blocks  = r_key_blocks;
  assign data_blocks = r_data_blocks;
`endif

endmodule
